// File: rtl/cpu_regfile_pkg.sv
// Shared register-file definitions used by decode, writeback and the
// register file itself: FSM state encoding and default geometry.
package cpu_regfile_pkg;

  // CLEAR: post-reset zeroing sweep in progress. RUN: normal traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy scoreboard. A claim sets a bit, a retiring write clears
// it; when both target the same register in one cycle the claim wins.
// Register 0 is hard-wired not busy. Callers pre-qualify set_en/clr_en.
module regfile_scoreboard_bits #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic              busy_ra,
  output logic              busy_rb
);

  logic [NUM_REGS-1:0] busy;

  // Busy flops: set by claim (priority), cleared by writeback, bit 0 pinned low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && (set_addr == ADDR_W'(i))) begin
          busy[i] <= 1'b1;
        end else if (clr_en && (clr_addr == ADDR_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_ra = busy[ra];
  assign busy_rb = busy[rb];

endmodule

// File: rtl/regfile_scoreboard.sv
// 2R/1W register file with hardware clear sweep, optional same-cycle
// write-to-read bypass and a RAW busy scoreboard.
// Handshake: there is no per-transfer backpressure. ready is a level; while
// it is low every we/claim_en is dropped and all read outputs read 0. While
// ready is high every we and claim_en pulse is accepted on that clock edge.
module regfile_scoreboard
  import cpu_regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output state_e            dbg_state
);

  localparam int CNT_W = ADDR_W + 1;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic               wr_ok;
  logic               claim_ok;
  logic               raw_busy_a;
  logic               raw_busy_b;

  assign wr_ok     = ready && we && (wa != '0);
  assign claim_ok  = ready && claim_en && (claim_addr != '0);
  assign dbg_state = state;

  // Clear-sweep FSM: walk cnt over every register, then enter RUN and raise ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(NUM_REGS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage: zeroed by the sweep, otherwise updated by qualified writeback.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[cnt[ADDR_W-1:0]] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  regfile_scoreboard_bits #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_bits (
    .clk      (clk),
    .rst      (rst),
    .set_en   (claim_ok),
    .set_addr (claim_addr),
    .clr_en   (wr_ok),
    .clr_addr (wa),
    .ra       (ra),
    .rb       (rb),
    .busy_ra  (raw_busy_a),
    .busy_rb  (raw_busy_b)
  );

  // Port A read mux: zero register, optional bypass of the retiring write, array.
  always_comb begin
    rd1    = '0;
    busy_a = 1'b0;
    if (ready && (ra != '0)) begin
      if ((BYPASS != 0) && we && (wa == ra)) begin
        rd1 = wd;
      end else begin
        rd1    = regs[ra];
        busy_a = raw_busy_a;
      end
    end
  end

  // Port B read mux: same structure as port A.
  always_comb begin
    rd2    = '0;
    busy_b = 1'b0;
    if (ready && (rb != '0)) begin
      if ((BYPASS != 0) && we && (wa == rb)) begin
        rd2 = wd;
      end else begin
        rd2    = regs[rb];
        busy_b = raw_busy_b;
      end
    end
  end

endmodule
